// File: rtl/credit_link_tx.sv
// Transmit side of a credit-flow-controlled link: valid/backpressure in,
// registered valid-only out, local credit counter refilled by return pulses.
module credit_link_tx #(
  parameter int unsigned Width    = 8,
  parameter int unsigned Credits  = 4,
  parameter int unsigned CntWidth = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [Width-1:0]    d,
  input  logic                d_valid,
  output logic                d_bp,
  output logic [Width-1:0]    q,
  output logic                q_valid,
  input  logic                credit_ret,
  output logic [CntWidth-1:0] credits,
  output logic                idle,
  output logic                err
);

  localparam logic [CntWidth-1:0] CreditsInit = CntWidth'(Credits);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [Width-1:0]    q_q;
  logic                q_valid_q;
  logic                err_q, err_d;
  logic                send;

  // Backpressure only looks at the counter and reset, never at d_valid/credit_ret.
  assign d_bp = ~resetn | (cnt_q == '0);
  assign send = d_valid & ~d_bp;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({send, credit_ret})
      2'b10: cnt_d = cnt_q - CntWidth'(1);
      2'b01: begin
        // A return with every slot already free is a far-end protocol error.
        if (cnt_q == CreditsInit) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= CreditsInit;
      q_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      q_valid_q <= send;
      err_q     <= err_d;
    end
  end

  // Data path is not reset; q is only meaningful while q_valid is high.
  always_ff @(posedge clk) begin
    if (send) begin
      q_q <= d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign credits = cnt_q;
  assign idle    = (cnt_q == CreditsInit);
  assign err     = err_q;

endmodule
